// File: rtl/acc_requant_q35.sv
// Requantizes a signed MAC accumulator to signed Q3.5 using scale, round and shift.
// Two-stage valid/ready pipeline with a sticky saturation counter.
module acc_requant_q35 #(
  parameter int ACC_W     = 24,
  parameter int SCALE_W   = 12,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SCALE_W-1:0]   cfg_scale,
  input  logic [4:0]           cfg_shift,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_W-1:0]     in_acc,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_count
);
  localparam int PROD_W = ACC_W + SCALE_W + 1;
  // One extra bit so adding the rounding term can never overflow.
  localparam int RND_W  = PROD_W + 1;
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(127);
  localparam logic signed [RND_W-1:0] SAT_MIN = -RND_W'(128);

  // S1: product, shift and last captured together at acceptance
  logic                     s1_valid_q;
  logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;
  logic [4:0]               s1_shift_q;
  logic                     s1_last_q;

  // S2: output register
  logic                     out_valid_q;
  logic [7:0]               out_data_q, out_data_d;
  logic                     out_last_q;
  logic [SAT_CNT_W-1:0]     sat_cnt_q, sat_cnt_d;

  logic s2_accept, s1_accept, s2_load, sat_d;

  assign s2_accept = !out_valid_q || out_ready;
  assign s1_accept = !s1_valid_q || s2_accept;
  assign s2_load   = s1_valid_q && s2_accept;
  assign in_ready  = s1_accept;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sat_count = sat_cnt_q;

  // Scale is zero-extended so the multiply stays signed without sign-flipping large scales.
  logic signed [PROD_W-1:0] acc_x, scl_x;
  assign acc_x     = {{(PROD_W-ACC_W){in_acc[ACC_W-1]}}, in_acc};
  assign scl_x     = {{(PROD_W-SCALE_W){1'b0}}, cfg_scale};
  assign s1_prod_d = acc_x * scl_x;

  logic signed [RND_W-1:0] prod_x, rnd_c, sum_c, r_c;

  always_comb begin
    prod_x = {s1_prod_q[PROD_W-1], s1_prod_q};
    rnd_c  = '0;
    if (s1_shift_q != 5'd0) rnd_c[s1_shift_q - 5'd1] = 1'b1;
    sum_c  = prod_x + rnd_c;
    r_c    = sum_c >>> s1_shift_q;
    sat_d  = 1'b0;
    out_data_d = r_c[7:0];
    if (r_c > SAT_MAX) begin
      out_data_d = 8'h7f;
      sat_d      = 1'b1;
    end else if (r_c < SAT_MIN) begin
      out_data_d = 8'h80;
      sat_d      = 1'b1;
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)
      sat_cnt_d = '0;
    else if (s2_load && sat_d && sat_cnt_q != '1)
      sat_cnt_d = sat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_shift_q  <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      if (s1_accept) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_prod_q  <= s1_prod_d;
          s1_shift_q <= cfg_shift;
          s1_last_q  <= in_last;
        end
      end
      if (s2_accept) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= out_data_d;
          out_last_q <= s1_last_q;
        end
      end
      sat_cnt_q <= sat_cnt_d;
    end
  end
endmodule

// File: tb/tb_acc_requant_q35.sv
// Scoreboard bench for acc_requant_q35: directed known-answer cases plus randomized
// traffic against a plain-arithmetic reference model.
module tb_acc_requant_q35;
  localparam int CW = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 0;
  logic          rst_n = 0;
  logic [11:0]   cfg_scale = 0;
  logic [4:0]    cfg_shift = 0;
  logic          in_valid = 0, in_last = 0, out_ready = 0, sat_clr = 0;
  logic [23:0]   in_acc = 0;
  logic          in_ready, out_valid, out_last;
  logic [7:0]    out_data;
  logic [CW-1:0] sat_count;

  acc_requant_q35 #(.ACC_W(24), .SCALE_W(12), .SAT_CNT_W(CW)) dut (
    .clk(clk), .reset(rst_n), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sat_clr(sat_clr), .sat_count(sat_count));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t sb[$];
  int   checks = 0, errors = 0, exp_sat = 0;
  bit   rand_rdy = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference: floor((acc*scale + half) / 2^shift), then clamp to int8.
  function automatic void model(input logic [23:0] raw, input logic [11:0] scl, input logic [4:0] sh,
                                output logic [7:0] d, output bit sat);
    longint p, num, den, q;
    p = longint'($signed(raw)) * longint'(scl);
    if (sh == 0) q = p;
    else begin
      den = longint'(1) << sh;
      num = p + den / 2;
      q = num / den;
      if (num % den != 0 && num < 0) q = q - 1;
    end
    sat = 0;
    if (q > 127) begin d = 8'h7f; sat = 1; end
    else if (q < -128) begin d = 8'h80; sat = 1; end
    else d = q[7:0];
  endfunction

  // Call only just after a rising edge. Returns just after the accepting edge.
  task automatic send(input logic [23:0] acc, input bit last, input logic [7:0] ed, input bit es);
    int n = 0;
    in_valid = 1; in_acc = acc; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) chk("send_timeout", 0, 1);
    else begin
      sb.push_back('{ed, last});
      if (es && exp_sat < SMAX) exp_sat++;
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_model(input logic [23:0] acc, input bit last);
    logic [7:0] d; bit s;
    model(acc, cfg_scale, cfg_shift, d, s);
    send(acc, last, d, s);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin n++; @(posedge clk); #1; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    sat_clr = 1; @(posedge clk); #1; sat_clr = 0;
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks hold-while-stalled.
  bit pv = 0, pr = 0, pl = 0, have_prev = 0;
  logic [7:0] pd = 0;
  always @(negedge clk) begin
    if (!rst_n) have_prev = 0;
    else begin
      if (have_prev && pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; have_prev = 1;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom % 4) != 0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sat_count", sat_count, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Known answer and latency: 1000*256/8192 rounds to 31
    out_ready = 1; cfg_scale = 256; cfg_shift = 13;
    send(24'd1000, 1, 8'd31, 0);
    @(negedge clk); chk("lat_s1_only", out_valid, 0);
    @(negedge clk); chk("lat_out_valid", out_valid, 1);
    chk("lat_out_data", out_data, 31);
    @(posedge clk); #1;
    drain();
    chk("ka_sat_count", sat_count, 0);

    // Rounding half toward +inf
    cfg_scale = 1; cfg_shift = 1;
    send(24'd3, 0, 8'd2, 0);
    send(-24'sd3, 0, 8'hff, 0);
    send(-24'sd4, 1, 8'hfe, 0);
    drain();

    // Saturation and counter clear
    cfg_scale = 4095; cfg_shift = 8;
    send(24'd100000, 0, 8'h7f, 1);
    send(-24'sd100000, 1, 8'h80, 1);
    drain();
    chk("sat_count_two", sat_count, 2);
    pulse_clr(); exp_sat = 0;
    chk("sat_clr", sat_count, 0);

    // Clear coinciding with an increment: clear wins
    send(24'd100000, 0, 8'h7f, 1);
    pulse_clr(); exp_sat = 0;
    drain();
    chk("clr_wins", sat_count, 0);

    // Counter sticks at all-ones
    for (int i = 0; i < SMAX + 5; i++) send(24'd100000, 0, 8'h7f, 1);
    drain();
    chk("sat_stick", sat_count, SMAX);
    pulse_clr(); exp_sat = 0;

    // Config change between samples affects only later samples
    cfg_scale = 256; cfg_shift = 13;
    send(24'd1000, 0, 8'd31, 0);
    cfg_shift = 2;
    send(24'd1, 1, 8'd64, 0);
    drain();

    // Backpressure: two accepts fill the pipe, third held upstream
    cfg_scale = 1; cfg_shift = 0; out_ready = 0;
    send(24'd10, 0, 8'd10, 0);
    send(-24'sd20, 0, 8'hec, 0);
    @(negedge clk); chk("bp_in_ready", in_ready, 0);
    @(posedge clk); #1;
    fork
      send(24'd30, 1, 8'd30, 0);
      begin repeat (5) @(posedge clk); #1; chk("bp_held", sb.size(), 2); out_ready = 1; end
    join
    drain();

    // Reset with both stages full discards everything
    cfg_scale = 4095; cfg_shift = 8; out_ready = 0;
    send(24'd100000, 0, 8'h7f, 1);
    send(24'd100000, 0, 8'h7f, 1);
    @(negedge clk); chk("pre_rst_sat", sat_count, 1);
    #2 rst_n = 0; #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sat_count", sat_count, 0);
    sb.delete(); exp_sat = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(negedge clk); chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1; out_ready = 1;
    repeat (5) @(posedge clk);
    @(negedge clk); chk("post_rst_no_stale", out_valid, 0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and per-sample config
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      logic [23:0] a;
      cfg_scale = 12'($urandom_range(0, 4095));
      cfg_shift = 5'($urandom_range(0, 31));
      if ($urandom % 2) a = 24'($signed($urandom_range(0, 4000)) - 2000);
      else a = 24'($urandom);
      send_model(a, 1'($urandom));
      if ($urandom % 5 == 0) begin @(posedge clk); #1; end
    end
    rand_rdy = 0; out_ready = 1;
    @(posedge clk); #1;
    drain();
    chk("rand_sat_count", sat_count, exp_sat);
    chk("rand_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
